// File: rtl/pb_entry_pkg.sv
// Shared key indices, operation codes and key decode for the push-button hex entry block.
package pb_entry_pkg;

  localparam int unsigned NUM_KEYS   = 20;
  localparam int unsigned KEY_BKSP   = 16;
  localparam int unsigned KEY_CLR    = 17;
  localparam int unsigned KEY_ENTER  = 19;
  localparam int unsigned MAX_DIGITS = 4;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_HEX,
    OP_BKSP,
    OP_CLR,
    OP_ENTER
  } key_op_e;

  function automatic key_op_e decode_op(input logic [4:0] idx);
    key_op_e op;
    op = OP_NONE;
    if (idx < 5'd16)                   op = OP_HEX;
    else if (idx == 5'(KEY_BKSP))      op = OP_BKSP;
    else if (idx == 5'(KEY_CLR))       op = OP_CLR;
    else if (idx == 5'(KEY_ENTER))     op = OP_ENTER;
    return op;
  endfunction

endpackage

// File: rtl/pb_hex_entry_keyenc.sv
// Combinational 20-to-5 priority encoder: the highest set index wins.
module pb_keyenc
  import pb_entry_pkg::*;
(
  input  logic [NUM_KEYS-1:0] keys,
  output logic [4:0]          idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        idx   = 5'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_hex_entry.sv
// Push-button hex operand entry: synchronizes keys, detects a single press event and edits a 4-digit operand.
// Optional anykey debouncer enabled by defining PB_DEBOUNCE_EN.
module pb_hex_entry
  import pb_entry_pkg::*;
(
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  output logic [15:0] value,
  output logic [2:0]  count,
  output logic [3:0]  digit,
  output logic        strobe,
  output logic [15:0] result,
  output logic        done
);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]          fill_q, fill_d;
  logic                arm_q, arm_d, lvl_q, lvl_d;
  logic [15:0]         value_q, value_d, result_q, result_d;
  logic [2:0]          count_q, count_d;
  logic [3:0]          digit_q, digit_d;
  logic                strobe_q, strobe_d, done_q, done_d;
  logic                anykey, level, key_evt;
  logic [4:0]          key_idx;
  logic                key_valid;
  key_op_e             op;
  logic                unused_pb;

  assign unused_pb = pb[20] ^ pb[18];

`ifdef PB_DEBOUNCE_EN
  logic       deb_q, deb_d;
  logic [1:0] cnt_q, cnt_d;

  // Level flips on the cycle the disagreement count would reach 3.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (anykey != deb_q) begin
      if (cnt_q == 2'd2) deb_d = ~deb_q;
      else               cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = deb_q;
`else
  assign level = anykey;
`endif

  pb_keyenc u_keyenc (
    .keys  (sync2_q),
    .idx   (key_idx),
    .valid (key_valid)
  );

  always_comb begin
    sync1_d  = {pb[19], 1'b0, pb[17:0]};
    sync2_d  = sync1_q;
    fill_d   = {fill_q[0], 1'b1};
    anykey   = |sync2_q;
    lvl_d    = level;
    // Arm only once the synchronizer holds post-reset samples and shows all keys released.
    arm_d    = arm_q | (fill_q[1] & ~anykey);
    key_evt  = level & ~lvl_q & arm_q;
    op       = (key_evt && key_valid) ? decode_op(key_idx) : OP_NONE;

    value_d  = value_q;
    count_d  = count_q;
    digit_d  = digit_q;
    result_d = result_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    case (op)
      OP_HEX: begin
        value_d  = {value_q[11:0], key_idx[3:0]};
        count_d  = (count_q < 3'(MAX_DIGITS)) ? count_q + 3'd1 : count_q;
        digit_d  = key_idx[3:0];
        strobe_d = 1'b1;
      end
      OP_BKSP: begin
        value_d = value_q >> 4;
        count_d = (count_q != '0) ? count_q - 3'd1 : count_q;
      end
      OP_CLR: begin
        value_d = '0;
        count_d = '0;
      end
      OP_ENTER: begin
        result_d = value_q;
        done_d   = 1'b1;
        value_d  = '0;
        count_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      fill_q   <= '0;
      arm_q    <= 1'b0;
      lvl_q    <= 1'b0;
      value_q  <= '0;
      count_q  <= '0;
      digit_q  <= '0;
      result_q <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      fill_q   <= fill_d;
      arm_q    <= arm_d;
      lvl_q    <= lvl_d;
      value_q  <= value_d;
      count_q  <= count_d;
      digit_q  <= digit_d;
      result_q <= result_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign value  = value_q;
  assign count  = count_q;
  assign digit  = digit_q;
  assign strobe = strobe_q;
  assign result = result_q;
  assign done   = done_q;

endmodule

// File: doc/pb_hex_entry.md
PB_HEX_ENTRY -- requirements
Module: pb_hex_entry

Interface
REQ-001 SHALL have these ports: `hz100`, input, 1 bit, system clock (all logic on its rising edge).
REQ-002 SHALL have `reset`, input, 1 bit, asynchronous, active-high.
REQ-003 SHALL have `pb`, input, 21 bits, raw push-buttons: [15:0] hex keys 0..F, [16] backspace, [17] clear, [19] enter; [18] and [20] unused.
REQ-004 SHALL have `value`, output, 16 bits, operand being entered, newest digit in [3:0].
REQ-005 SHALL have `count`, output, 3 bits, digits entered, 0..4.
REQ-006 SHALL have `digit`, output, 4 bits, last hex key accepted.
REQ-007 SHALL have `strobe`, output, 1 bit, 1-cycle pulse on each accepted hex key.
REQ-008 SHALL have `result`, output, 16 bits, operand latched by enter.
REQ-009 SHALL have `done`, output, 1 bit, 1-cycle pulse when `result` updates.

Function
REQ-010 SHALL pass pb[19:0] through a 2-flop synchronizer; pb[20:18] unused bits SHALL be ignored except pb[19].
REQ-011 SHALL form `anykey` = OR of synchronized pb[19:0] and register it; a key event fires only on `anykey` 0->1.
REQ-012 Latency: pb first sampled high at edge t -> outputs update at edge t+2.
REQ-013 Additional buttons pressed while any key is held SHALL be ignored; a held key SHALL produce exactly one event.
REQ-014 Several keys rising in the same cycle: highest index wins.
REQ-015 Hex key k: `value` <= {value[11:0],k}; `count` <= min(count+1,4); `digit` <= k; `strobe` = 1 for one cycle. A fifth digit drops the oldest nibble.
REQ-016 Backspace: `value` <= value>>4; `count` <= max(count-1,0); no strobe.
REQ-017 Clear: `value` <= 0; `count` <= 0; `digit`, `result` unchanged.
REQ-018 Enter: `result` <= value; `done` = 1 for one cycle; `value` <= 0; `count` <= 0. Enter with `count`=0 still latches 0 and pulses `done`.
REQ-019 Outside events, all registers SHALL hold and `strobe`/`done` SHALL be 0.

Reset
REQ-020 On `reset` high, asynchronously: `value`, `count`, `digit`, `result` = 0; `strobe`, `done` = 0; synchronizer, edge, and debounce state cleared.
REQ-021 A key held across reset release SHALL NOT produce an event until it is released and pressed again.

Configuration
REQ-022 Macro PB_DEBOUNCE_EN defined: `anykey` SHALL pass through a debouncer.
- 2-bit counter increments while synchronized `anykey` differs from the debounced level, and resets to 0 when they are equal.
- The debounced level flips when the counter reaches 3.
- Edge detection uses the debounced level; latency becomes t+5; the key code is taken from the synchronized bus in the event cycle.
REQ-023 Macro PB_DEBOUNCE_EN undefined: no debouncer; latency t+2 per REQ-012.

Structure
REQ-024 Package `pb_entry_pkg` SHALL hold:
- KEY_BKSP=16, KEY_CLR=17, KEY_ENTER=19, MAX_DIGITS=4;
- enum `key_op_e` {OP_NONE, OP_HEX, OP_BKSP, OP_CLR, OP_ENTER}.
REQ-025 Sub-module `pb_keyenc`: combinational 20-to-5 highest-index priority encoder, with `valid` output.

Verification
REQ-026 Press/release pb[9] four times -> `value`=16'h9999, `count`=4, four `strobe` pulses, `digit`=9.
REQ-027 From 16'h9999, press pb[1] -> `value`=16'h9991, `count`=4; then backspace -> 16'h0999, `count`=3.
REQ-028 From 16'h0999, press enter -> `result`=16'h0999, one-cycle `done`, `value`=0, `count`=0.
REQ-029 Assert pb[3] and pb[5] together -> `digit`=5 only.
- Hold pb[5] for 10 cycles and add pb[7] -> no further events.
REQ-030 Reset asserted mid-entry (`value`=16'h00AB) with pb[2] held -> all outputs 0 immediately.
- No event until pb[2] is released and pressed again.
REQ-031 With PB_DEBOUNCE_EN, a 2-cycle pb[4] glitch -> no event.
- A 6-cycle press -> one event at t+5.
